ring_router_vc: RTL and testbench

- Parametrised next-generation bidirectional ring router node: cw, ccw and PE input/output ports, NUM_VC=2 virtual channels per port.
- Each VC buffer is a BUF_DEPTH-entry FIFO (previously a single location).
- Hop field position and width are configurable, and each output has round-robin arbitration.
- Sits between two ring neighbours and one processing element; the polarity output is used by neighbours and the PE to phase-align VC usage.

---
 rtl/ring_router_vc_pkg.sv | 32 +++
 rtl/ring_router_vc_if.sv | 12 +
 rtl/ring_router_vc_fifo.sv | 67 ++++++
 rtl/ring_router_vc.sv | 229 ++++++++++++++++++++++
 tb/tb_ring_router_vc.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_router_vc_pkg.sv
// ring_noc_pkg: shared constants, port enumeration and the hop-field helper
// used by the bidirectional ring router node and its VC FIFOs.
package ring_noc_pkg;

    // Default packet field layout.
    localparam int DFLT_HOP_LSB = 48;
    localparam int DFLT_HOP_W   = 8;
    localparam int DFLT_DIR_BIT = 62;
    localparam int VC_BIT       = 63;

    localparam int NUM_PORTS = 3;
    localparam int NUM_VC    = 2;

    // Widest packet the hop helper handles; narrower packets are zero-extended.
    localparam int PKT_MAX_W = 256;

    typedef enum logic [1:0] {
        PORT_CW  = 2'd0,
        PORT_CCW = 2'd1,
        PORT_PE  = 2'd2
    } port_e;

    // Logical right shift by one of the hop field [lsb +: w]; other bits untouched.
    function automatic logic [PKT_MAX_W-1:0] hop_shift(input logic [PKT_MAX_W-1:0] pkt,
                                                       input int lsb,
                                                       input int w);
        logic [PKT_MAX_W-1:0] mask;
        mask = ((PKT_MAX_W'(1) << w) - PKT_MAX_W'(1)) << lsb;
        return (pkt & ~mask) | (((pkt & mask) >> 1) & mask);
    endfunction

endpackage

// File: rtl/ring_router_vc_if.sv
// ring_router_vc_if: one send/ready/data link of the ring router.
// master drives send and data, slave drives ready.
interface ring_router_vc_if #(
    parameter int PACKET_SIZE = 64
);
    logic                   s;
    logic                   r;
    logic [PACKET_SIZE-1:0] d;

    modport master (output s, output d, input r);
    modport slave  (input s, input d, output r);
endinterface

// File: rtl/ring_router_vc_fifo.sv
// vc_fifo: synchronous FIFO holding one virtual channel of one router port.
// Pointers wrap modulo DEPTH, so any DEPTH >= 1 is supported.
module vc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control state; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ring_router_vc.sv
// ring_router_vc: bidirectional ring router node with cw, ccw and PE ports,
// two virtual channels per port. Links use VC[polarity] while the crossbar
// moves packets on VC[~polarity], so no FIFO is read and written in one cycle.
// Optional build macro RING_ROUTER_PERF_CNT_EN adds saturating 16-bit send
// counters cw_cnt, ccw_cnt and pe_cnt.
module ring_router_vc
    import ring_noc_pkg::*;
#(
    parameter int PACKET_SIZE = 64,
    parameter int BUF_DEPTH   = 2,
    parameter int HOP_LSB     = DFLT_HOP_LSB,
    parameter int HOP_W       = DFLT_HOP_W,
    parameter int DIR_BIT     = DFLT_DIR_BIT
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    polarity,
    ring_router_vc_if.slave         cwi,
    ring_router_vc_if.slave         ccwi,
    ring_router_vc_if.slave         pei,
    ring_router_vc_if.master        cwo,
    ring_router_vc_if.master        ccwo,
    ring_router_vc_if.master        peo
`ifdef RING_ROUTER_PERF_CNT_EN
    ,
    output logic [15:0]             cw_cnt,
    output logic [15:0]             ccw_cnt,
    output logic [15:0]             pe_cnt
`endif
);
    logic pol_q, pol_d;
    logic sw_en [NUM_VC];

    logic                   in_s     [NUM_PORTS];
    logic [PACKET_SIZE-1:0] in_d     [NUM_PORTS];
    logic                   in_ri    [NUM_PORTS];
    logic                   out_r    [NUM_PORTS];
    logic                   out_so   [NUM_PORTS];
    logic [PACKET_SIZE-1:0] out_do   [NUM_PORTS];

    logic                   in_push  [NUM_PORTS][NUM_VC];
    logic                   in_pop   [NUM_PORTS][NUM_VC];
    logic                   in_full  [NUM_PORTS][NUM_VC];
    logic                   in_empty [NUM_PORTS][NUM_VC];
    logic [PACKET_SIZE-1:0] in_head  [NUM_PORTS][NUM_VC];

    logic                   out_push [NUM_PORTS][NUM_VC];
    logic                   out_pop  [NUM_PORTS][NUM_VC];
    logic                   out_full [NUM_PORTS][NUM_VC];
    logic                   out_empty[NUM_PORTS][NUM_VC];
    logic [PACKET_SIZE-1:0] out_head [NUM_PORTS][NUM_VC];
    logic [PACKET_SIZE-1:0] out_din  [NUM_PORTS][NUM_VC];

    port_e                  tgt      [NUM_PORTS][NUM_VC];
    logic                   req      [NUM_PORTS][NUM_VC];
    logic                   arb_g0   [NUM_PORTS][NUM_VC];
    logic                   arb_g1   [NUM_PORTS][NUM_VC];

    // Link signals gathered into port-indexed arrays.
    assign in_s[PORT_CW]   = cwi.s;
    assign in_d[PORT_CW]   = cwi.d;
    assign in_s[PORT_CCW]  = ccwi.s;
    assign in_d[PORT_CCW]  = ccwi.d;
    assign in_s[PORT_PE]   = pei.s;
    assign in_d[PORT_PE]   = pei.d;
    assign cwi.r           = in_ri[PORT_CW];
    assign ccwi.r          = in_ri[PORT_CCW];
    assign pei.r           = in_ri[PORT_PE];

    assign out_r[PORT_CW]  = cwo.r;
    assign out_r[PORT_CCW] = ccwo.r;
    assign out_r[PORT_PE]  = peo.r;
    assign cwo.s           = out_so[PORT_CW];
    assign cwo.d           = out_do[PORT_CW];
    assign ccwo.s          = out_so[PORT_CCW];
    assign ccwo.d          = out_do[PORT_CCW];
    assign peo.s           = out_so[PORT_PE];
    assign peo.d           = out_do[PORT_PE];

    // VC0 switches while polarity is 1, VC1 while polarity is 0.
    assign pol_d    = ~pol_q;
    assign polarity = pol_q;
    assign sw_en[0] = pol_q;
    assign sw_en[1] = ~pol_q;

    // Phase bit toggles every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end

    // Link handshakes on VC[polarity]: ready, accept, send and pop.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_ri[i]  = !in_full[i][pol_q];
            out_so[i] = !out_empty[i][pol_q] && out_r[i];
            out_do[i] = out_so[i] ? out_head[i][pol_q] : '0;
            for (int v = 0; v < NUM_VC; v++) begin
                in_push[i][v] = !sw_en[v] && in_s[i] && !in_full[i][v];
                out_pop[i][v] = !sw_en[v] && out_so[i];
            end
        end
    end

    // Route computation and switch requests on VC[~polarity].
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int v = 0; v < NUM_VC; v++) begin
                tgt[i][v] = PORT_PE;
                if (i == int'(PORT_CW)) begin
                    tgt[i][v] = in_head[i][v][HOP_LSB] ? PORT_CW : PORT_PE;
                end else if (i == int'(PORT_CCW)) begin
                    tgt[i][v] = in_head[i][v][HOP_LSB] ? PORT_CCW : PORT_PE;
                end else begin
                    tgt[i][v] = in_head[i][v][DIR_BIT] ? PORT_CW : PORT_CCW;
                end
                req[i][v] = sw_en[v] && !in_empty[i][v] && !out_full[tgt[i][v]][v];
            end
        end
    end

    // Input pops: each input is requester 0 or 1 of the outputs it can reach.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            in_pop[PORT_CW][v]  = arb_g0[PORT_CW][v]  | arb_g0[PORT_PE][v];
            in_pop[PORT_CCW][v] = arb_g0[PORT_CCW][v] | arb_g1[PORT_PE][v];
            in_pop[PORT_PE][v]  = arb_g1[PORT_CW][v]  | arb_g1[PORT_CCW][v];
        end
    end

    // Per-output, per-VC round-robin arbiters and crossbar data path.
    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        // Requester 0 is cw for cw/PE outputs and ccw for the ccw output;
        // requester 1 is PE for cw/ccw outputs and ccw for the PE output.
        localparam int S0 = (o == int'(PORT_PE)) ? int'(PORT_CW) : o;
        localparam int S1 = (o == int'(PORT_PE)) ? int'(PORT_CCW) : int'(PORT_PE);
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            logic                   req0, req1, g0, g1;
            logic                   ptr_q, ptr_d;
            logic [PACKET_SIZE-1:0] src_pkt;

            assign req0 = req[S0][v] && (tgt[S0][v] == port_e'(o));
            assign req1 = req[S1][v] && (tgt[S1][v] == port_e'(o));
            assign g0   = req0 && (!req1 || !ptr_q);
            assign g1   = req1 && (!req0 || ptr_q);
            assign ptr_d = g0 ? 1'b1 : (g1 ? 1'b0 : ptr_q);

            assign arb_g0[o][v]   = g0;
            assign arb_g1[o][v]   = g1;
            assign src_pkt        = g0 ? in_head[S0][v] : in_head[S1][v];
            assign out_push[o][v] = g0 | g1;
            assign out_din[o][v]  =
                PACKET_SIZE'(hop_shift(PKT_MAX_W'(src_pkt), HOP_LSB, HOP_W));

            // Priority pointer moves to the requester that lost (or was absent).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ptr_q <= 1'b0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end
    end

    // Input and output VC buffers for every port.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
            vc_fifo #(
                .WIDTH (PACKET_SIZE),
                .DEPTH (BUF_DEPTH)
            ) u_in_fifo (
                .clk   (clk),
                .rst   (reset),
                .push  (in_push[p][v]),
                .din   (in_d[p]),
                .pop   (in_pop[p][v]),
                .dout  (in_head[p][v]),
                .full  (in_full[p][v]),
                .empty (in_empty[p][v])
            );

            vc_fifo #(
                .WIDTH (PACKET_SIZE),
                .DEPTH (BUF_DEPTH)
            ) u_out_fifo (
                .clk   (clk),
                .rst   (reset),
                .push  (out_push[p][v]),
                .din   (out_din[p][v]),
                .pop   (out_pop[p][v]),
                .dout  (out_head[p][v]),
                .full  (out_full[p][v]),
                .empty (out_empty[p][v])
            );
        end
    end

`ifdef RING_ROUTER_PERF_CNT_EN
    logic [15:0] cnt_q [NUM_PORTS];
    logic [15:0] cnt_d [NUM_PORTS];

    // Saturating per-output send counters.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = (out_so[i] && (cnt_q[i] != 16'hFFFF)) ? cnt_q[i] + 16'd1 : cnt_q[i];
        end
    end

    // Counter state cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cw_cnt  = cnt_q[PORT_CW];
    assign ccw_cnt = cnt_q[PORT_CCW];
    assign pe_cnt  = cnt_q[PORT_PE];
`endif

endmodule

// File: tb/tb_ring_router_vc.sv
// Scoreboard bench for ring_router_vc: stimulus pushes hand-computed expected
// packets per output port; a negedge monitor pops and compares every send.
module tb_ring_router_vc;
    import ring_noc_pkg::*;

    localparam int PW = 64;

    logic clk = 1'b0;
    logic reset;
    logic polarity;

    ring_router_vc_if #(.PACKET_SIZE(PW)) cwi_if ();
    ring_router_vc_if #(.PACKET_SIZE(PW)) ccwi_if ();
    ring_router_vc_if #(.PACKET_SIZE(PW)) pei_if ();
    ring_router_vc_if #(.PACKET_SIZE(PW)) cwo_if ();
    ring_router_vc_if #(.PACKET_SIZE(PW)) ccwo_if ();
    ring_router_vc_if #(.PACKET_SIZE(PW)) peo_if ();

`ifdef RING_ROUTER_PERF_CNT_EN
    logic [15:0] cw_cnt, ccw_cnt, pe_cnt;
`endif

    ring_router_vc #(
        .PACKET_SIZE (PW),
        .BUF_DEPTH   (2),
        .HOP_LSB     (48),
        .HOP_W       (8),
        .DIR_BIT     (62)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .cwi      (cwi_if),
        .ccwi     (ccwi_if),
        .pei      (pei_if),
        .cwo      (cwo_if),
        .ccwo     (ccwo_if),
        .peo      (peo_if)
`ifdef RING_ROUTER_PERF_CNT_EN
        ,
        .cw_cnt   (cw_cnt),
        .ccw_cnt  (ccw_cnt),
        .pe_cnt   (pe_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [PW-1:0] expq [3][$];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon_port(input int p, input logic so, input logic [PW-1:0] dat, input string nm);
        if (so) begin
            if (expq[p].size() == 0) begin
                check({nm, "_unexpected_send"}, 1, 0);
            end else begin
                check({nm, "_data"}, dat, expq[p].pop_front());
            end
        end else begin
            check({nm, "_idle_data"}, dat, 0);
        end
    endtask

    // Monitor: compare every output send against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon_port(0, cwo_if.s, cwo_if.d, "cw_out");
            mon_port(1, ccwo_if.s, ccwo_if.d, "ccw_out");
            mon_port(2, peo_if.s, peo_if.d, "pe_out");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pol(input logic want);
        int n = 0;
        while (polarity !== want && n < 4) begin
            tick();
            n++;
        end
        if (polarity !== want) check("polarity_wait", polarity, want);
    endtask

    task automatic idle_inputs();
        cwi_if.s = 0;  cwi_if.d = '0;
        ccwi_if.s = 0; ccwi_if.d = '0;
        pei_if.s = 0;  pei_if.d = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_polarity"}, polarity, 0);
        check({tag, "_cwso"}, cwo_if.s, 0);
        check({tag, "_ccwso"}, ccwo_if.s, 0);
        check({tag, "_peso"}, peo_if.s, 0);
        check({tag, "_cwri"}, cwi_if.r, 1);
        check({tag, "_ccwri"}, ccwi_if.r, 1);
        check({tag, "_peri"}, pei_if.r, 1);
    endtask

    initial begin
        int k;
        int n;
        reset = 1'b1;
        idle_inputs();
        cwo_if.r = 1; ccwo_if.r = 1; peo_if.r = 1;
        repeat (2) tick();
        check_reset_state("rst");
        reset = 1'b0;
        tick();

        // cw forward, hop 3 -> 1, two-cycle latency
        wait_pol(0);
        cwi_if.s = 1; cwi_if.d = 64'h12_03_3456_789A_BCDE;
        expq[0].push_back(64'h12_01_3456_789A_BCDE);
        tick();
        idle_inputs();
        @(negedge clk);
        check("lat_t1_cwso", cwo_if.s, 0);
        tick();
        @(negedge clk);
        check("lat_t2_cwso", cwo_if.s, 1);
        repeat (4) tick();

        // cw and ccw both to PE on VC0: pointer at 0, cw wins first
        wait_pol(0);
        cwi_if.s = 1;  cwi_if.d = 64'h00_00_C1C1_0000_0001;
        ccwi_if.s = 1; ccwi_if.d = 64'h00_00_CCC1_0000_0002;
        expq[2].push_back(64'h00_00_C1C1_0000_0001);
        expq[2].push_back(64'h00_00_CCC1_0000_0002);
        tick();
        idle_inputs();
        repeat (6) tick();

        // single cw grant leaves the pointer favouring ccw
        wait_pol(0);
        cwi_if.s = 1; cwi_if.d = 64'h00_00_C2C2_0000_0003;
        expq[2].push_back(64'h00_00_C2C2_0000_0003);
        tick();
        idle_inputs();
        repeat (4) tick();

        // repeat conflict: ccw now wins first
        wait_pol(0);
        cwi_if.s = 1;  cwi_if.d = 64'h00_00_C3C3_0000_0004;
        ccwi_if.s = 1; ccwi_if.d = 64'h00_00_CCC3_0000_0005;
        expq[2].push_back(64'h00_00_CCC3_0000_0005);
        expq[2].push_back(64'h00_00_C3C3_0000_0004);
        tick();
        idle_inputs();
        repeat (6) tick();

        // PE inject ccw (DIR=0) with hop 4 -> 2; cw stays idle
        wait_pol(0);
        pei_if.s = 1; pei_if.d = 64'h01_04_AAAA_5555_0F0F;
        expq[1].push_back(64'h01_02_AAAA_5555_0F0F);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pe_inject_cwso_idle", cwo_if.s, 0);
            tick();
        end

        // PE inject cw (DIR=1) with hop 0 still injects
        pei_if.s = 1; pei_if.d = 64'h40_00_1111_2222_3333;
        expq[0].push_back(64'h40_00_1111_2222_3333);
        tick();
        idle_inputs();
        repeat (5) tick();

        // backpressure: fill cw out and cw in FIFOs of both VCs
        cwo_if.r = 0;
        wait_pol(0);
        k = 0;
        n = 0;
        while (k < 8 && n < 40) begin
            if (cwi_if.r) begin
                cwi_if.s = 1;
                cwi_if.d = 64'hD0_01_0000_0000_0000 | 64'(k);
                expq[0].push_back(64'hD0_00_0000_0000_0000 | 64'(k));
                k++;
            end else begin
                cwi_if.s = 0;
            end
            tick();
            n++;
        end
        idle_inputs();
        check("bp_accepted", k, 8);
        check("bp_cwri_phase0", cwi_if.r, 0);
        tick();
        check("bp_cwri_phase1", cwi_if.r, 0);
        wait_pol(0);
        cwo_if.r = 1;
        repeat (20) tick();

        // mid-traffic reset discards buffered packets
        cwo_if.r = 0;
        wait_pol(0);
        cwi_if.s = 1; cwi_if.d = 64'hEE_01_0000_0000_0001;
        tick();
        cwi_if.d = 64'hEE_01_0000_0000_0002;
        tick();
        idle_inputs();
        tick();
        #2;
        cwo_if.r = 1;
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();

`ifdef RING_ROUTER_PERF_CNT_EN
        // counters: 3 PE sends, then saturation
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            wait_pol(0);
            cwi_if.s = 1; cwi_if.d = 64'h00_00_0000_0000_0100 | 64'(i);
            expq[2].push_back(64'h00_00_0000_0000_0100 | 64'(i));
            tick();
            idle_inputs();
            repeat (3) tick();
        end
        repeat (4) tick();
        check("pe_cnt_3", pe_cnt, 3);
        check("cw_cnt_0", cw_cnt, 0);
        check("ccw_cnt_0", ccw_cnt, 0);
        for (int i = 0; i < 70000; i++) begin
            if (cwi_if.r) begin
                cwi_if.s = 1; cwi_if.d = 64'(i);
                expq[2].push_back(64'(i));
            end else begin
                cwi_if.s = 0;
            end
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        check("pe_cnt_sat", pe_cnt, 16'hFFFF);
`endif

        check("drain_cw", expq[0].size(), 0);
        check("drain_ccw", expq[1].size(), 0);
        check("drain_pe", expq[2].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
